// File: rtl/paddsb_simd.sv
// Packed per-lane saturating add/sub (signed/unsigned) with sticky saturation flags.
// Latency: 2 cycles from input handshake to out_valid; one result per cycle when unstalled.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready = !out_valid | out_ready.
module paddsb_simd #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LANE_W-1:0]  in_a,
    input  logic [LANES*LANE_W-1:0]  in_b,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*LANE_W-1:0]  out_data,
    output logic [LANES-1:0]         out_sat,
    output logic [LANES-1:0]         sat_sticky,
    input  logic                     clr_sat
);
    localparam int W = LANES * LANE_W;
    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic           advance;
    logic           s1_vld;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [1:0]     s1_op;
    logic [W-1:0]   lane_res;
    logic [LANES-1:0] lane_sat;
    logic           out_xfer;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign out_xfer = out_valid && out_ready;

    // Each lane is evaluated one bit wider so overflow/carry is visible without cross-lane carries.
    always_comb begin
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W:0]   ea;
        logic [LANE_W:0]   eb;
        logic [LANE_W:0]   sum;
        logic [LANE_W-1:0] res;
        logic              sat;
        lane_res = '0;
        lane_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            la  = s1_a[i*LANE_W +: LANE_W];
            lb  = s1_b[i*LANE_W +: LANE_W];
            ea  = s1_op[1] ? {1'b0, la} : {la[LANE_W-1], la};
            eb  = s1_op[1] ? {1'b0, lb} : {lb[LANE_W-1], lb};
            sum = s1_op[0] ? (ea - eb) : (ea + eb);
            res = sum[LANE_W-1:0];
            sat = 1'b0;
            if (s1_op[1]) begin
                if (sum[LANE_W]) begin
                    sat = 1'b1;
                    res = s1_op[0] ? '0 : '1;
                end
            end else if (sum[LANE_W] != sum[LANE_W-1]) begin
                sat = 1'b1;
                res = sum[LANE_W] ? SMIN : SMAX;
            end
            lane_res[i*LANE_W +: LANE_W] = res;
            lane_sat[i] = sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (advance) begin
            s1_vld    <= in_valid;
            out_valid <= s1_vld;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= in_op;
            end
            if (s1_vld) begin
                out_data <= lane_res;
                out_sat  <= lane_sat;
            end
        end
    end

    // A transfer in the clearing cycle still records its own flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= '0;
        end else if (clr_sat) begin
            sat_sticky <= out_xfer ? out_sat : '0;
        end else if (out_xfer) begin
            sat_sticky <= sat_sticky | out_sat;
        end
    end
endmodule

// File: tb/tb_paddsb_simd.sv
// Directed bench for paddsb_simd with LANE_W=4, LANES=4: arithmetic vectors, stall, sticky, reset.
module tb_paddsb_simd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_sat;
    logic [3:0]  sat_sticky;
    logic        clr_sat;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] held;
    logic [3:0]  nib;

    paddsb_simd #(.LANE_W(4), .LANES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .clr_sat    (clr_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [15:0] ed, input logic [3:0] es,
                          input logic clr);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_dat"}, {16'd0, out_data}, {16'd0, ed});
        chk({tag, "_sat"}, {28'd0, out_sat}, {28'd0, es});
        clr_sat = clr;
        @(negedge clk);
        clr_sat = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1'b1; clr_sat = 1'b0;
        #3;
        chk("rst_vld",    {31'd0, out_valid}, 32'd0);
        chk("rst_rdy",    {31'd0, in_ready},  32'd1);
        chk("rst_dat",    {16'd0, out_data},  32'd0);
        chk("rst_sticky", {28'd0, sat_sticky}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sadd",     16'h5C31, 16'h4B21, 2'b00, 16'h7852, 4'b1100, 1'b0);
        run_op("sadd_bnd", 16'h0003, 16'h0004, 2'b00, 16'h0007, 4'b0000, 1'b0);
        run_op("ssub",     16'h7830, 16'hF120, 2'b01, 16'h7810, 4'b1100, 1'b0);
        run_op("ssub_bnd", 16'h0007, 16'h0000, 2'b01, 16'h0007, 4'b0000, 1'b0);
        run_op("ssub_neg", 16'h0008, 16'h0000, 2'b01, 16'h0008, 4'b0000, 1'b0);
        run_op("uadd",     16'hF821, 16'h1831, 2'b10, 16'hFF52, 4'b1100, 1'b0);
        run_op("usub",     16'h1530, 16'h2710, 2'b11, 16'h0020, 4'b1100, 1'b0);

        // sticky accumulate, then clear racing a transfer
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        chk("sticky_clr", {28'd0, sat_sticky}, 32'd0);
        run_op("stk1", 16'h5C31, 16'h4B21, 2'b00, 16'h7852, 4'b1100, 1'b0);
        chk("sticky_a", {28'd0, sat_sticky}, 32'hC);
        run_op("stk2", 16'h0007, 16'h0001, 2'b00, 16'h0007, 4'b0001, 1'b0);
        chk("sticky_b", {28'd0, sat_sticky}, 32'hD);
        run_op("stk3", 16'h0070, 16'h0010, 2'b00, 16'h0070, 4'b0010, 1'b1);
        chk("sticky_clr_set", {28'd0, sat_sticky}, 32'h2);

        // stream of 6 with a 3-cycle consumer stall
        begin
            int sent = 0;
            int recv = 0;
            for (int c = 0; c < 40 && recv < 6; c++) begin
                out_ready = !(c >= 4 && c <= 6);
                in_valid  = (sent < 6);
                in_a      = {4{sent[3:0]}};
                in_b      = 16'h1111;
                in_op     = 2'b10;
                #1;
                if (!out_ready) begin
                    chk("stall_rdy", {31'd0, in_ready}, 32'd0);
                    chk("stall_vld", {31'd0, out_valid}, 32'd1);
                    if (c > 4) chk("stall_hold", {16'd0, out_data}, {16'd0, held});
                end
                held = out_data;
                if (in_valid && in_ready) sent++;
                if (out_valid && out_ready) begin
                    nib = recv[3:0] + 4'd1;
                    chk("stream_dat", {16'd0, out_data}, {16'd0, {4{nib}}});
                    recv++;
                end
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("stream_cnt", recv, 6);
            chk("stream_sent", sent, 6);
            repeat (3) begin
                @(negedge clk);
                chk("stream_nodup", {31'd0, out_valid}, 32'd0);
            end
        end

        // async reset with two sets in flight
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h5C31; in_b = 16'h4B21; in_op = 2'b00;
        @(negedge clk);
        in_a = 16'hF821; in_b = 16'h1831; in_op = 2'b10;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",    {31'd0, out_valid},  32'd0);
        chk("arst_dat",    {16'd0, out_data},   32'd0);
        chk("arst_sat",    {28'd0, out_sat},    32'd0);
        chk("arst_sticky", {28'd0, sat_sticky}, 32'd0);
        chk("arst_rdy",    {31'd0, in_ready},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
